// File: rtl/kd_tree_pipe.sv
// KD-tree traversal pipeline: one tree level per stage, one query per cycle.
// Internal nodes are loaded breadth-first; each result carries leaf index, tag and patch.
module kd_tree_pipe #(
    parameter int DEPTH     = 7,
    parameter int NUM_DIMS  = 5,
    parameter int DIM_WIDTH = 11,
    parameter int IDX_WIDTH = 3,
    parameter int TAG_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_start,
    input  logic                            wr_valid,
    input  logic [IDX_WIDTH+DIM_WIDTH-1:0]  wr_data,
    output logic                            loaded,
    output logic                            busy,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_DIMS*DIM_WIDTH-1:0]   in_patch,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DEPTH-1:0]                out_leaf,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic [NUM_DIMS*DIM_WIDTH-1:0]   out_patch
);

    localparam int NODES = (1 << DEPTH) - 1;
    localparam int NW    = IDX_WIDTH + DIM_WIDTH;
    localparam int PW    = NUM_DIMS * DIM_WIDTH;
    localparam logic [DEPTH-1:0] LAST_ADR = DEPTH'(NODES - 1);

    logic [NW-1:0]        node_q [NODES];
    logic [DEPTH-1:0]     wadr_q, wadr_d;
    logic                 loaded_q, loaded_d;

    logic                 advance;
    logic                 accept;
    logic                 loadGo;
    logic                 wrGo;

    logic [DEPTH-1:0]     stValid_q;
    logic [DEPTH-1:0]     stPath_q  [DEPTH];
    logic [TAG_WIDTH-1:0] stTag_q   [DEPTH];
    logic [PW-1:0]        stPatch_q [DEPTH];
    logic [DEPTH-1:0]     goRight;

    logic                 outValid_q;
    logic [DEPTH-1:0]     outLeaf_q;
    logic [TAG_WIDTH-1:0] outTag_q;
    logic [PW-1:0]        outPatch_q;

    assign busy      = (|stValid_q) || outValid_q;
    assign advance   = !outValid_q || out_ready;
    assign in_ready  = loaded_q && advance;
    assign accept    = in_valid && in_ready;
    assign loadGo    = load_start && !busy;
    // A load_start in the same cycle as a node word always suppresses the write.
    assign wrGo      = wr_valid && !loaded_q && !load_start;

    assign loaded    = loaded_q;
    assign out_valid = outValid_q;
    assign out_leaf  = outLeaf_q;
    assign out_tag   = outTag_q;
    assign out_patch = outPatch_q;

    always_comb begin
        wadr_d   = wadr_q;
        loaded_d = loaded_q;
        if (loadGo) begin
            wadr_d   = '0;
            loaded_d = 1'b0;
        end else if (wrGo) begin
            if (wadr_q == LAST_ADR) begin
                loaded_d = 1'b1;
            end else begin
                wadr_d = wadr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wadr_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            wadr_q   <= wadr_d;
            loaded_q <= loaded_d;
        end
    end

    // Node contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wrGo) begin
            node_q[wadr_q] <= wr_data;
        end
    end

    for (genvar l = 0; l < DEPTH; l++) begin : gStage
        logic [PW-1:0]        curPatch;
        logic [DEPTH-1:0]     curPath;
        logic [DEPTH-1:0]     nodeIdx;
        logic [NW-1:0]        nodeWord;
        logic [IDX_WIDTH-1:0] dim;
        logic [DIM_WIDTH-1:0] split;
        logic [DIM_WIDTH-1:0] value;

        if (l == 0) begin : gRoot
            assign curPatch = in_patch;
            assign curPath  = '0;
        end else begin : gInner
            assign curPatch = stPatch_q[l-1];
            assign curPath  = stPath_q[l-1];
        end

        // curPath holds only the l bits decided so far, so this lands inside level l.
        assign nodeIdx  = DEPTH'((1 << l) - 1) + curPath;
        assign nodeWord = node_q[nodeIdx];
        assign dim      = nodeWord[NW-1 -: IDX_WIDTH];
        assign split    = nodeWord[DIM_WIDTH-1:0];

        // Out-of-range dimension indices fall through to dimension 0.
        always_comb begin
            value = curPatch[DIM_WIDTH-1:0];
            for (int k = 1; k < NUM_DIMS; k++) begin
                if (int'(dim) == k) begin
                    value = curPatch[k*DIM_WIDTH +: DIM_WIDTH];
                end
            end
        end

        assign goRight[l] = value > split;
    end

    // The whole pipe shifts or holds as one; bubbles travel with the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stValid_q  <= '0;
            outValid_q <= 1'b0;
            outLeaf_q  <= '0;
            outTag_q   <= '0;
            outPatch_q <= '0;
            for (int l = 0; l < DEPTH; l++) begin
                stPath_q[l]  <= '0;
                stTag_q[l]   <= '0;
                stPatch_q[l] <= '0;
            end
        end else if (advance) begin
            stValid_q[0] <= accept;
            stPath_q[0]  <= DEPTH'(goRight[0]);
            stTag_q[0]   <= in_tag;
            stPatch_q[0] <= in_patch;
            for (int l = 1; l < DEPTH; l++) begin
                stValid_q[l] <= stValid_q[l-1];
                stPath_q[l]  <= (stPath_q[l-1] << 1) | DEPTH'(goRight[l]);
                stTag_q[l]   <= stTag_q[l-1];
                stPatch_q[l] <= stPatch_q[l-1];
            end
            outValid_q <= stValid_q[DEPTH-1];
            outLeaf_q  <= stPath_q[DEPTH-1];
            outTag_q   <= stTag_q[DEPTH-1];
            outPatch_q <= stPatch_q[DEPTH-1];
        end
    end

endmodule

// File: tb/tb_kd_tree_pipe.sv
// Directed testbench for kd_tree_pipe on a 3-level, 3-dimension tree.
// Drives and samples on the falling edge; expected leaves are hand-derived.
module tb_kd_tree_pipe;

    localparam int DEPTH     = 3;
    localparam int NUM_DIMS  = 3;
    localparam int DIM_WIDTH = 8;
    localparam int IDX_WIDTH = 2;
    localparam int TAG_WIDTH = 8;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        wr_valid;
    logic [9:0]  wr_data;
    logic        loaded;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_patch;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_leaf;
    logic [7:0]  out_tag;
    logic [23:0] out_patch;

    kd_tree_pipe #(
        .DEPTH(DEPTH), .NUM_DIMS(NUM_DIMS), .DIM_WIDTH(DIM_WIDTH),
        .IDX_WIDTH(IDX_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .loaded(loaded), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_leaf(out_leaf),
        .out_tag(out_tag), .out_patch(out_patch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] patch;
        logic [7:0]  tag;
        logic [2:0]  leaf;
    } vec_t;

    vec_t       vecs [5];
    logic [9:0] nodeTab [7];
    int         testsRun    = 0;
    int         testsFailed = 0;

    function automatic logic [23:0] mkPatch(input logic [7:0] d0, input logic [7:0] d1,
                                            input logic [7:0] d2);
        return {d2, d1, d0};
    endfunction

    function automatic logic [9:0] mkNode(input logic [1:0] dim, input logic [7:0] split);
        return {dim, split};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one query and expects it to be taken at the next rising edge.
    task automatic applyStimulus(input logic [23:0] p, input logic [7:0] t, input string name);
        in_valid = 1'b1;
        in_patch = p;
        in_tag   = t;
        #1;
        checkOutput(name, in_ready, 1);
        @(negedge clk);
    endtask

    task automatic loadTree(input logic [9:0] root);
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_data  = (i == 0) ? root : nodeTab[i];
            if (i == 6) begin
                checkOutput("loaded low before last write", loaded, 0);
                checkOutput("in_ready low before loaded", in_ready, 0);
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        checkOutput("loaded after last write", loaded, 1);
    endtask

    task automatic waitValid(input int limit, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int seen;

        nodeTab[0] = mkNode(0, 100);
        nodeTab[1] = mkNode(1, 50);
        nodeTab[2] = mkNode(1, 200);
        nodeTab[3] = mkNode(2, 10);
        nodeTab[4] = mkNode(2, 20);
        nodeTab[5] = mkNode(2, 30);
        nodeTab[6] = mkNode(2, 40);

        // Paths: root d0>100, then d1 vs 50/200, then d2 vs 10/20/30/40; ties go left.
        vecs[0] = '{patch: mkPatch(100, 50, 10),  tag: 8'h21, leaf: 3'b000};
        vecs[1] = '{patch: mkPatch(101, 51, 11),  tag: 8'h22, leaf: 3'b100};
        vecs[2] = '{patch: mkPatch(0, 255, 41),   tag: 8'h23, leaf: 3'b011};
        vecs[3] = '{patch: mkPatch(50, 60, 15),   tag: 8'h24, leaf: 3'b010};
        vecs[4] = '{patch: mkPatch(255, 201, 41), tag: 8'h25, leaf: 3'b111};

        rst = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
        in_valid = 1'b0; in_patch = '0; in_tag = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset loaded", loaded, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_leaf", out_leaf, 0);
        checkOutput("reset out_tag", out_tag, 0);
        rst = 1'b0;

        // A query held during loading must not be taken.
        in_valid = 1'b1;
        in_patch = mkPatch(1, 2, 3);
        in_tag   = 8'hEE;
        loadTree(nodeTab[0]);
        in_valid = 1'b0;
        checkOutput("no result from pre-load query", out_valid, 0);

        // Surplus node word once loaded.
        wr_valid = 1'b1;
        wr_data  = mkNode(2, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        checkOutput("loaded after surplus write", loaded, 1);

        applyStimulus(mkPatch(150, 250, 35), 8'h11, "accept first query");
        in_valid = 1'b0;
        waitValid(10, lat);
        checkOutput("first query latency", lat, 3);
        checkOutput("first query leaf", out_leaf, 3'b110);
        checkOutput("first query tag", out_tag, 8'h11);
        checkOutput("first query patch", out_patch, mkPatch(150, 250, 35));
        @(negedge clk);
        checkOutput("single result only", out_valid, 0);

        // Back-to-back burst; each result must appear DEPTH+1 negedges after it is driven.
        for (int j = 0; j < 5 + 5; j++) begin
            if (j < 5) begin
                in_valid = 1'b1;
                in_patch = vecs[j].patch;
                in_tag   = vecs[j].tag;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (j < 5) checkOutput("burst accept", in_ready, 1);
            if (j >= 4 && j - 4 < 5) begin
                checkOutput("burst valid", out_valid, 1);
                checkOutput("burst leaf", out_leaf, vecs[j-4].leaf);
                checkOutput("burst tag", out_tag, vecs[j-4].tag);
            end else if (j >= 4) begin
                checkOutput("burst no extra result", out_valid, 0);
            end
            @(negedge clk);
        end

        // Backpressure with three queries in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i].patch, vecs[i].tag, "stall accept");
        in_valid = 1'b0;
        waitValid(10, lat);
        checkOutput("stall first result valid", out_valid, 1);
        for (int h = 0; h < 5; h++) begin
            in_valid   = 1'b1;
            in_patch   = mkPatch(7, 7, 7);
            in_tag     = 8'hEE;
            load_start = (h == 1);
            #1;
            checkOutput("stall in_ready", in_ready, 0);
            checkOutput("stall out_valid", out_valid, 1);
            checkOutput("stall out_leaf frozen", out_leaf, vecs[0].leaf);
            checkOutput("stall out_tag frozen", out_tag, vecs[0].tag);
            checkOutput("stall out_patch frozen", out_patch, vecs[0].patch);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        checkOutput("load_start while busy ignored", loaded, 1);
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            checkOutput("drain valid", out_valid, 1);
            checkOutput("drain leaf", out_leaf, vecs[r].leaf);
            checkOutput("drain tag", out_tag, vecs[r].tag);
            @(negedge clk);
        end
        seen = 0;
        for (int r = 0; r < 4; r++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checkOutput("drain no duplicates", seen, 0);
        checkOutput("idle before reload", busy, 0);

        // Reload with a new root split.
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checkOutput("loaded cleared by load_start", loaded, 0);
        loadTree(mkNode(0, 200));
        applyStimulus(mkPatch(150, 250, 35), 8'h33, "accept after reload");
        in_valid = 1'b0;
        waitValid(10, lat);
        checkOutput("reload latency", lat, 3);
        checkOutput("reload leaf", out_leaf, 3'b011);
        checkOutput("reload tag", out_tag, 8'h33);
        @(negedge clk);

        // Reset with two queries in flight.
        applyStimulus(vecs[3].patch, vecs[3].tag, "accept before reset");
        applyStimulus(vecs[4].patch, vecs[4].tag, "accept before reset");
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid-flight reset out_valid", out_valid, 0);
        checkOutput("mid-flight reset busy", busy, 0);
        checkOutput("mid-flight reset loaded", loaded, 0);
        checkOutput("mid-flight reset in_ready", in_ready, 0);
        seen = 0;
        for (int r = 0; r < 8; r++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checkOutput("no stale result after reset", seen, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
